// File: rtl/settings_bus_arbiter.sv
// Settings-bus arbiter: SPI writes take absolute priority; in-band writes are queued
// in a small FIFO and issued in slots left free by SPI.
module settings_bus_arbiter #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned AW         = 7,
  parameter int unsigned DW         = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_spi_strobe,
  input  logic [AW-1:0] i_spi_addr,
  input  logic [DW-1:0] i_spi_data,
  input  logic          i_ib_strobe,
  input  logic [AW-1:0] i_ib_addr,
  input  logic [DW-1:0] i_ib_data,
  input  logic          i_ib_hold,
  input  logic          i_clear_status,
  output logic          o_serial_strobe,
  output logic [AW-1:0] o_serial_addr,
  output logic [DW-1:0] o_serial_data,
  output logic          o_ib_full,
  output logic          o_ib_pending,
  output logic [7:0]    o_drop_count
);

  localparam int unsigned          Depth    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [AW-1:0]         r_mem_addr [Depth];
  logic [DW-1:0]         r_mem_data [Depth];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [7:0]            r_drop_count;
  logic                  r_serial_strobe;
  logic [AW-1:0]         r_serial_addr;
  logic [DW-1:0]         r_serial_data;
  logic                  r_ib_full;
  logic                  r_ib_pending;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_count_next;

  // Issue decision uses the queue state before this cycle's push: no bypass.
  assign w_pop  = !i_spi_strobe && (r_count != '0) && !i_ib_hold;
  assign w_push = i_ib_strobe && ((r_count != DepthCnt) || w_pop);
  assign w_drop = i_ib_strobe && !w_push;

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Queue storage needs no reset; only pointers and count define validity.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= i_ib_addr;
      r_mem_data[r_wr_ptr] <= i_ib_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_drop_count    <= '0;
      r_serial_strobe <= 1'b0;
      r_serial_addr   <= '0;
      r_serial_data   <= '0;
      r_ib_full       <= 1'b0;
      r_ib_pending    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count      <= w_count_next;
      r_ib_full    <= (w_count_next == DepthCnt);
      r_ib_pending <= (w_count_next != '0);

      if (i_clear_status) begin
        r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end

      if (i_spi_strobe) begin
        r_serial_strobe <= 1'b1;
        r_serial_addr   <= i_spi_addr;
        r_serial_data   <= i_spi_data;
      end else if (w_pop) begin
        r_serial_strobe <= 1'b1;
        r_serial_addr   <= r_mem_addr[r_rd_ptr];
        r_serial_data   <= r_mem_data[r_rd_ptr];
      end else begin
        r_serial_strobe <= 1'b0;
      end
    end
  end

  assign o_serial_strobe = r_serial_strobe;
  assign o_serial_addr   = r_serial_addr;
  assign o_serial_data   = r_serial_data;
  assign o_ib_full       = r_ib_full;
  assign o_ib_pending    = r_ib_pending;
  assign o_drop_count    = r_drop_count;

endmodule

// File: doc/settings_bus_arbiter.md
Name: settings_bus_arbiter

Overview:
Shares the single 7-bit address / 32-bit data settings bus between two masters: the SPI path from serial_io and the in-band register path from register_io.
- SPI writes have absolute priority and are never delayed more than one cycle.
- In-band writes are queued in a small FIFO and issued in slots where no SPI write occurs, so a collision no longer silently loses the in-band write.
- Its outputs drive setting_reg, master_control, io_pins, adc_interface and rx_chain in the clk64 domain.

Parameters:
- DEPTH_LOG2, 2, log2 of in-band queue depth (default 4 entries).
- AW, 7, settings address width.
- DW, 32, settings data width.

Ports:
- clock  in  1  settings-domain clock (clk64).
- reset  in  1  asynchronous, active-high reset.
- spi_strobe  in  1  single-cycle write pulse from serial_io.
- spi_addr  in  AW  SPI write address, valid with spi_strobe.
- spi_data  in  DW  SPI write data, valid with spi_strobe.
- ib_strobe  in  1  single-cycle write pulse from register_io.
- ib_addr  in  AW  in-band write address.
- ib_data  in  DW  in-band write data.
- ib_hold  in  1  blocks issue of queued in-band writes while high.
- clear_status  in  1  synchronous clear of drop_count.
- serial_strobe  out  1  registered write strobe to settings consumers.
- serial_addr  out  AW  registered write address.
- serial_data  out  DW  registered write data.
- ib_full  out  1  in-band queue holds 2**DEPTH_LOG2 entries.
- ib_pending  out  1  in-band queue non-empty.
- drop_count  out  8  saturating count of in-band writes lost to a full queue.

Behaviour:
- Reset (async assert, released on clock):
  - serial_strobe=0, serial_addr=0, serial_data=0.
  - Queue empty; ib_full=0, ib_pending=0, drop_count=0.
  - Queue contents are don't-care.
- Per-cycle issue decision, evaluated on the current-cycle inputs and queue state before any push:
  - spi_strobe=1: next cycle drives serial_strobe=1 with spi_addr/spi_data. SPI latency is exactly 1 cycle, unconditionally.
  - else if queue non-empty and ib_hold=0: pop the head entry; next cycle drives serial_strobe=1 with the head's addr/data.
  - else: next cycle serial_strobe=0, and serial_addr/serial_data hold their last values.
- In-band latency: an in-band write accepted in cycle N enters the queue at the edge ending N. It is eligible in cycle N+1, so serial_strobe is asserted in cycle N+2 if uncontended. The queue is never bypassed.
- Push rule:
  - ib_strobe=1 with count < depth: write at the tail.
  - ib_strobe=1 with count = depth and a pop in the same cycle: accepted, count unchanged.
  - ib_strobe=1 with count = depth and no pop: the write is dropped and drop_count increments.
- drop_count saturates at 255. clear_status=1 forces it to 0; if a drop occurs in the same cycle, clear wins.
- Ordering:
  - In-band writes issue in arrival order.
  - SPI writes may overtake queued in-band writes.
  - At most one serial_strobe per cycle; back-to-back SPI strobes starve the queue for their duration, which is legal.
- ib_full and ib_pending are registered and derived from the post-update count.
- Pointer arithmetic:
  - rd_ptr and wr_ptr are DEPTH_LOG2 bits and wrap modulo depth.
  - count is DEPTH_LOG2+1 bits.
- ib_hold blocks only in-band issue; pushes continue while it is high.
- Reset asserted mid-operation discards queued entries and aborts any pending output. serial_strobe is low in the first cycle after reset deassertion.

Test Plan:
- Uncontended SPI: spi_strobe at cycle 10 with addr=0x05, data=0x12345678 -> serial_strobe=1 only in cycle 11 with the same addr/data; ib_pending stays 0.
- Uncontended in-band: ib_strobe at cycle 10 with addr=0x0A, data=0xDEADBEEF -> ib_pending=1 in cycle 11; serial_strobe=1 in cycle 12 with addr=0x0A; ib_pending=0 in cycle 12.
- Collision: spi_strobe and ib_strobe both in cycle 20 (SPI addr=0x01, IB addr=0x02) -> cycle 21 issues addr 0x01, cycle 22 issues addr 0x02; no drops.
- Overflow: ib_hold=1, six ib_strobe pulses in consecutive cycles -> ib_full=1 after the 4th; drop_count=2. Release ib_hold -> four strobes issue in order on consecutive cycles, then ib_pending=0.
- Full with simultaneous pop: queue full, ib_hold=0, no SPI, ib_strobe on the same cycle a pop occurs -> drop_count unchanged; the new entry issues after the existing three.
- Saturation, clear and reset: force 300 drops -> drop_count=255. clear_status -> 0. Assert reset with 3 entries queued -> all outputs 0 and the queue empty, with no stale strobe after release.
